// File: rtl/rgb2gray_avalon_st.sv
// RGB888 to 8-bit luma converter with Avalon-ST packet framing.
// Ports:
//   csi_clkrst_clk/reset : clock, async active-high reset
//   asi_sink1_*          : 24-bit RGB packet sink {R,G,B}
//   aso_source1_*        : 8-bit gray packet source
//   frame_err_o          : one-cycle pulse per framing error
//   frame_count_o        : well-formed frames emitted (wraps)
module rgb2gray_avalon_st #(
    parameter int IMG_X_SIZE = 320,
    parameter int IMG_Y_SIZE = 240
) (
    input  logic        csi_clkrst_clk,
    input  logic        csi_clkrst_reset,
    input  logic [23:0] asi_sink1_data,
    input  logic        asi_sink1_startofpacket,
    input  logic        asi_sink1_endofpacket,
    input  logic        asi_sink1_valid,
    output logic        asi_sink1_ready,
    output logic [7:0]  aso_source1_data,
    output logic        aso_source1_startofpacket,
    output logic        aso_source1_endofpacket,
    output logic        aso_source1_valid,
    input  logic        aso_source1_ready,
    output logic        frame_err_o,
    output logic [15:0] frame_count_o
);

    localparam int N  = IMG_X_SIZE * IMG_Y_SIZE;
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE,
        FRAME,
        DROP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          pend_q, pend_d;
    logic [23:0]   pend_pix_q, pend_pix_d;
    logic          err_q, err_d;

    logic          s1_valid_q;
    logic [15:0]   s1_r_q, s1_g_q, s1_b_q;
    logic          s1_sop_q, s1_eop_q, s1_good_q;

    logic          s2_valid_q;
    logic [7:0]    s2_data_q;
    logic          s2_sop_q, s2_eop_q, s2_good_q;

    logic [15:0]   fcnt_q;

    logic          adv1, adv2, acc;
    logic          fwd, zero;
    logic          t_sop, t_eop, t_good;
    logic [23:0]   pix;
    logic [15:0]   p_r, p_g, p_b;
    logic [15:0]   sum;

    assign adv2 = ~s2_valid_q | aso_source1_ready;
    assign adv1 = ~s1_valid_q | adv2;

    // Sink stalls for one cycle while a restart pixel waits in the hold slot
    assign asi_sink1_ready = adv1 & ~pend_q;
    assign acc = asi_sink1_valid & asi_sink1_ready;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_pix_d = pend_pix_q;
        err_d      = 1'b0;
        fwd        = 1'b0;
        zero       = 1'b0;
        t_sop      = 1'b0;
        t_eop      = 1'b0;
        t_good     = 1'b0;
        if (pend_q) begin
            // Replay the held restart pixel as the first beat of a new frame
            if (adv1) begin
                fwd     = 1'b1;
                t_sop   = 1'b1;
                cnt_d   = CW'(1);
                state_d = FRAME;
                pend_d  = 1'b0;
            end
        end else if (acc) begin
            case (state_q)
                FRAME: begin
                    fwd = 1'b1;
                    if (cnt_q == LAST) begin
                        t_eop = 1'b1;
                        if (asi_sink1_endofpacket) begin
                            t_good  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            err_d   = 1'b1;
                            state_d = DROP;
                        end
                    end else if (asi_sink1_endofpacket) begin
                        t_eop   = 1'b1;
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end else if (asi_sink1_startofpacket) begin
                        // Close old packet with a zero filler eop beat
                        t_eop      = 1'b1;
                        zero       = 1'b1;
                        err_d      = 1'b1;
                        pend_d     = 1'b1;
                        pend_pix_d = asi_sink1_data;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    if (asi_sink1_startofpacket) begin
                        fwd   = 1'b1;
                        t_sop = 1'b1;
                        if (N == 1) begin
                            t_eop   = 1'b1;
                            t_good  = 1'b1;
                            state_d = IDLE;
                        end else if (asi_sink1_endofpacket) begin
                            t_eop   = 1'b1;
                            err_d   = 1'b1;
                            state_d = IDLE;
                        end else begin
                            cnt_d   = CW'(1);
                            state_d = FRAME;
                        end
                    end else if (asi_sink1_endofpacket) begin
                        state_d = IDLE;
                    end
                end
            endcase
        end
    end

    assign pix = pend_q ? pend_pix_q : (zero ? 24'h0 : asi_sink1_data);
    assign p_r = 16'(pix[23:16]) * 16'd77;
    assign p_g = 16'(pix[15:8]) * 16'd150;
    assign p_b = 16'(pix[7:0]) * 16'd29;
    assign sum = s1_r_q + s1_g_q + s1_b_q + 16'd128;

    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_pix_q <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_pix_q <= pend_pix_d;
            err_q      <= err_d;
        end
    end

    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= '0;
            s1_g_q     <= '0;
            s1_b_q     <= '0;
            s1_sop_q   <= 1'b0;
            s1_eop_q   <= 1'b0;
            s1_good_q  <= 1'b0;
        end else if (adv1) begin
            s1_valid_q <= fwd;
            if (fwd) begin
                s1_r_q    <= p_r;
                s1_g_q    <= p_g;
                s1_b_q    <= p_b;
                s1_sop_q  <= t_sop;
                s1_eop_q  <= t_eop;
                s1_good_q <= t_good;
            end
        end
    end

    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            s2_valid_q <= 1'b0;
            s2_data_q  <= '0;
            s2_sop_q   <= 1'b0;
            s2_eop_q   <= 1'b0;
            s2_good_q  <= 1'b0;
        end else if (adv2) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_data_q <= sum[15:8];
                s2_sop_q  <= s1_sop_q;
                s2_eop_q  <= s1_eop_q;
                s2_good_q <= s1_good_q;
            end
        end
    end

    always_ff @(posedge csi_clkrst_clk or posedge csi_clkrst_reset) begin
        if (csi_clkrst_reset) begin
            fcnt_q <= '0;
        end else if (s2_valid_q & aso_source1_ready & s2_eop_q & s2_good_q) begin
            fcnt_q <= fcnt_q + 16'd1;
        end
    end

    assign aso_source1_valid         = s2_valid_q;
    assign aso_source1_data          = s2_valid_q ? s2_data_q : 8'h0;
    assign aso_source1_startofpacket = s2_valid_q & s2_sop_q;
    assign aso_source1_endofpacket   = s2_valid_q & s2_eop_q;
    assign frame_err_o               = err_q;
    assign frame_count_o             = fcnt_q;

endmodule
